pwla_logit: RTL and testbench

Sequential inverse of the piecewise-linear sigmoid: accepts a sigmoid-domain value `y` in Q5.10 (0 = 0.0, 1024 = 1.0) and returns the signed Q5.10 `x` that the team's PWL sigmoid maps to `y`. Sits downstream of the sigmoid datapath, for calibration and readback of activations. Uses a 13-step bit-serial search over the forward PWL curve, with a valid/ready handshake on both sides.

---
 rtl/pwla_logit.sv | 127 ++++++++++++
 tb/tb_pwla_logit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pwla_logit.sv
// Bit-serial inverse of the PWL sigmoid: maps a Q5.10 sigmoid value y to the signed Q5.10 x.
// Optional macro PWLA_LOGIT_SAT_FLAG_EN adds a registered sat_flag output.
module pwla_logit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] x
`ifdef PWLA_LOGIT_SAT_FLAG_EN
  ,
  output logic        sat_flag
`endif
);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [10:0] r_t;
  logic        r_sign;
  logic [3:0]  r_bit;
  logic [12:0] r_c;
  logic [15:0] r_x;

  logic        w_accept;
  logic [10:0] w_yc;
  logic [10:0] w_t;
  logic        w_sign;
  logic [12:0] w_trial;
  logic [12:0] w_c_next;
  logic [12:0] w_mag;
  logic [15:0] w_x;

  // Forward PWL sigmoid for non-negative m; output saturates at 1.0 (1024).
  function automatic logic [10:0] f_pwl(input logic [12:0] m);
    logic [11:0] v;
    if (m < 13'd1024) begin
      v = 12'(m >> 2) + 12'd512;
    end else if (m < 13'd2432) begin
      v = 12'(m >> 3) + 12'd640;
    end else begin
      v = 12'(m >> 5) + 12'd868;
    end
    if (v > 12'd1024) begin
      v = 12'd1024;
    end
    return v[10:0];
  endfunction

  assign w_accept = in_valid && in_ready;
  assign w_yc     = (y > 16'd1024) ? 11'd1024 : y[10:0];
  assign w_sign   = (w_yc < 11'd512);
  assign w_t      = w_sign ? (11'd1024 - w_yc) : w_yc;

  // Keep the trial bit only while the curve is still below the target.
  assign w_trial  = r_c | (13'd1 << r_bit);
  assign w_c_next = (f_pwl(w_trial) < r_t) ? w_trial : r_c;
  assign w_mag    = (r_t == 11'd512) ? 13'd0 : (w_c_next + 13'd1);
  assign w_x      = r_sign ? (16'd0 - {3'b000, w_mag}) : {3'b000, w_mag};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_next = StSearch;
      StSearch: if (r_bit == 4'd0) w_state_next = StDone;
      StDone:   if (out_ready) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

`ifdef PWLA_LOGIT_SAT_FLAG_EN
  logic r_sat;
  assign sat_flag = r_sat;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_t    <= 11'd0;
      r_sign <= 1'b0;
      r_bit  <= 4'd0;
      r_c    <= 13'd0;
      r_x    <= 16'd0;
`ifdef PWLA_LOGIT_SAT_FLAG_EN
      r_sat  <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_t    <= w_t;
            r_sign <= w_sign;
            r_bit  <= 4'd12;
            r_c    <= 13'd0;
          end
        end
        StSearch: begin
          r_c <= w_c_next;
          if (r_bit != 4'd0) begin
            r_bit <= r_bit - 4'd1;
          end else begin
            r_x <= w_x;
`ifdef PWLA_LOGIT_SAT_FLAG_EN
            r_sat <= (r_t == 11'd1024);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign x         = r_x;

endmodule

// File: tb/tb_pwla_logit.sv
// Directed and swept self-checking bench for pwla_logit.
module tb_pwla_logit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x;
`ifdef PWLA_LOGIT_SAT_FLAG_EN
  logic        sat_flag;
`endif

  int n_cmp;
  int n_err;

  pwla_logit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x)
`ifdef PWLA_LOGIT_SAT_FLAG_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_f(input int m);
    int v;
    if (m < 1024) v = (m >> 2) + 512;
    else if (m < 2432) v = (m >> 3) + 640;
    else v = (m >> 5) + 868;
    if (v > 1024) v = 1024;
    return v;
  endfunction

  function automatic int ref_t(input int yv);
    int yc;
    yc = (yv > 1024) ? 1024 : yv;
    return (yc >= 512) ? yc : 1024 - yc;
  endfunction

  // Linear scan for the smallest m reaching the target.
  function automatic logic [15:0] ref_x(input int yv);
    int t;
    int m;
    logic [15:0] r;
    t = ref_t(yv);
    m = 0;
    while (ref_f(m) < t) m++;
    r = 16'(m);
    if (((yv > 1024) ? 1024 : yv) < 512) r = 16'd0 - r;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_req(input logic [15:0] yv);
    in_valid = 1'b1;
    y        = yv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [15:0] xo, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    xo = x;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [15:0] yv, input logic [15:0] xe,
                          input logic sat_e);
    logic [15:0] xo;
    int lat;
    start_req(yv);
    wait_out(xo, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'd13);
    check_eq({tag, "_x"}, {16'd0, xo}, {16'd0, xe});
`ifdef PWLA_LOGIT_SAT_FLAG_EN
    check_eq({tag, "_sat"}, {31'd0, sat_flag}, {31'd0, sat_e});
`else
    if (sat_e) begin end
`endif
    handoff();
  endtask

  initial begin
    logic [15:0] xo;
    int lat;
    int t;
    int mag;
    bit seen;
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    y         = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_x", {16'd0, x}, 32'd0);
`ifdef PWLA_LOGIT_SAT_FLAG_EN
    check_eq("rst_sat", {31'd0, sat_flag}, 32'd0);
`endif

    directed("y512", 16'd512, 16'h0000, 1'b0);
    directed("y768", 16'd768, 16'h0400, 1'b0);
    directed("y256", 16'd256, 16'hFC00, 1'b0);
    directed("y600", 16'd600, 16'h0160, 1'b0);
    directed("y944", 16'd944, 16'h0980, 1'b0);
    directed("y1024", 16'd1024, 16'h1380, 1'b1);
    directed("y0", 16'd0, 16'hEC80, 1'b1);
    directed("y2000", 16'd2000, 16'h1380, 1'b1);

    // Backpressure: DONE held while a stray request is pulsed.
    start_req(16'd600);
    wait_out(xo, lat);
    check_eq("bp_lat", 32'(lat), 32'd13);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        in_valid = 1'b1;
        y        = 16'd100;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_x", {16'd0, x}, 32'h0160);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    handoff();
    check_eq("bp_rel_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("bp_rel_x_hold", {16'd0, x}, 32'h0160);

    // Reset five cycles into a search.
    start_req(16'd900);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_x", {16'd0, x}, 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("mid_rst_no_out", {31'd0, seen}, 32'd0);
    directed("post_rst_y768", 16'd768, 16'h0400, 1'b0);

    // Sweep against the reference scan and the bracketing property.
    for (int yv = 0; yv <= 1100; yv++) begin
      start_req(16'(yv));
      wait_out(xo, lat);
      check_eq($sformatf("sweep_x_%0d", yv), {16'd0, xo}, {16'd0, ref_x(yv)});
      t   = ref_t(yv);
      mag = xo[15] ? int'(16'd0 - xo) : int'(xo);
      if (mag > 0) begin
        check_eq($sformatf("sweep_bracket_%0d", yv),
                 {31'd0, (ref_f(mag) >= t) && (ref_f(mag - 1) < t)}, 32'd1);
      end
      handoff();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
